// File: rtl/mem_data_reg.sv
// ----------------------------------------------------------------------------
// mem_data_reg
//
// Memory data register for a two-syllable core-memory word. An accepted read
// strobe captures the full 28-bit sense word into a buffer and the selected
// 14-bit syllable into MDR. The syllable is then shifted out serially, LSB
// first: 13 data bits followed by the parity bit. Shifting is paced by the
// TIME bit enable and can be aborted early by SYNC. The sequence ends with a
// one-cycle restore phase that drives the captured word back onto INH. A
// one-cycle DONE pulse follows the restore phase.
//
// Optional build macro:
//   MEM_PARITY_CHECK_EN  when defined, LOAD flags PERR if the selected 14 bits
//                        hold an even number of ones (odd parity expected).
//                        When undefined, PERR is tied to 0 and no parity logic
//                        is built.
//
// Ports:
//   CLK      in   1   system clock, all state on the rising edge
//   RSTN     in   1   asynchronous active-low reset
//   RD       in   1   read strobe (one-cycle pulse)
//   SYL0N    in   1   syllable 0 select, active low, sampled with RD
//   SYL1N    in   1   syllable 1 select, active low, sampled with RD
//   SENSE    in  28   sense word: [13:0] syllable 0, [27:14] syllable 1
//                     (bit 13 / bit 27 are the syllable parity bits)
//   TIME     in   1   bit-time enable for the serial shift
//   SYNC     in   1   word-start marker; aborts an active shift
//   SER      out  1   serial data bit
//   SERV     out  1   SER valid
//   MDR      out 14   selected syllable, parallel
//   BUSY     out  1   a read is in progress
//   DONE     out  1   one-cycle pulse after the restore phase
//   RESTORE  out  1   restore phase active
//   INH      out 28   restore/inhibit drive pattern (0 outside restore)
//   PERR     out  1   parity error, sticky until the next accepted read
//   SELERR   out  1   ambiguous syllable select, sticky until next read
//   OVR      out  1   read strobe seen while busy, sticky until next read
// ----------------------------------------------------------------------------
module mem_data_reg (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        RD,
    input  logic        SYL0N,
    input  logic        SYL1N,
    input  logic [27:0] SENSE,
    input  logic        TIME,
    input  logic        SYNC,
    output logic        SER,
    output logic        SERV,
    output logic [13:0] MDR,
    output logic        BUSY,
    output logic        DONE,
    output logic        RESTORE,
    output logic [27:0] INH,
    output logic        PERR,
    output logic        SELERR,
    output logic        OVR
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_RESTORE = 2'd3;

    localparam logic [3:0] LAST_BIT = 4'd13;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [27:0] word_buf;
    logic [13:0] mdr_q;
    logic        ser_q;
    logic        done_q;
    logic        selerr_q;
    logic        ovr_q;

    logic [13:0] sel_syl;
    logic        sel_err;
    logic [15:0] mdr_ext;
    logic        busy;
    logic        shift_fire;

    // Syllable selection from the active-low selects. The two ambiguous
    // encodings still pick a syllable (both low -> 0, both high -> 1) but
    // raise the select error.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_syl = SENSE[13:0];
        sel_err = 1'b0;
        case ({SYL0N, SYL1N})
            2'b01:   sel_syl = SENSE[13:0];
            2'b10:   sel_syl = SENSE[27:14];
            2'b00: begin
                sel_syl = SENSE[13:0];
                sel_err = 1'b1;
            end
            default: begin
                sel_syl = SENSE[27:14];
                sel_err = 1'b1;
            end
        endcase
    end

    // Zero-extended copy so the 4-bit counter can index it without ever
    // stepping outside the vector.
    assign mdr_ext    = {2'b00, mdr_q};
    assign busy       = (state != ST_IDLE);
    // A bit is delivered only on a TIME cycle of SHIFT that is not being
    // aborted by SYNC.
    assign shift_fire = (state == ST_SHIFT) && TIME && !SYNC;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            count    <= 4'd0;
            word_buf <= 28'd0;
            mdr_q    <= 14'd0;
            ser_q    <= 1'b0;
            done_q   <= 1'b0;
            selerr_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (RD) begin
                        word_buf <= SENSE;
                        mdr_q    <= sel_syl;
                        selerr_q <= sel_err;
                        ovr_q    <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= 4'd0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (SYNC) begin
                        state <= ST_RESTORE;
                    end else if (TIME) begin
                        // SER keeps the last delivered bit across TIME=0 cycles.
                        ser_q <= mdr_ext[count];
                        count <= count + 4'd1;
                        if (count == LAST_BIT) begin
                            state <= ST_RESTORE;
                        end
                    end
                end
                default: begin
                    // Restore lasts one cycle; DONE marks the idle cycle after it.
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                end
            endcase

            // A strobe arriving mid-read is dropped; only the overrun is noted.
            if (RD && busy) begin
                ovr_q <= 1'b1;
            end
        end
    end

`ifdef MEM_PARITY_CHECK_EN
    logic perr_q;

    // Cleared by an accepted read, then evaluated once in LOAD against the
    // captured syllable (data plus parity bit must hold an odd number of ones).
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            perr_q <= 1'b0;
        end else if (state == ST_IDLE && RD) begin
            perr_q <= 1'b0;
        end else if (state == ST_LOAD) begin
            perr_q <= ~(^mdr_q);
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    assign SER     = shift_fire ? mdr_ext[count] : ser_q;
    assign SERV    = shift_fire;
    assign MDR     = mdr_q;
    assign BUSY    = busy;
    assign DONE    = done_q;
    assign RESTORE = (state == ST_RESTORE);
    assign INH     = (state == ST_RESTORE) ? word_buf : 28'd0;
    assign SELERR  = selerr_q;
    assign OVR     = ovr_q;

endmodule

// File: tb/tb_mem_data_reg.sv
// ----------------------------------------------------------------------------
// tb_mem_data_reg
//
// Self-checking bench for mem_data_reg. A read-level reference model tracks
// the phase of each read (load, shift, restore, done), the number of serial
// bits delivered and the sticky flags. It derives every expected output from
// the captured sense word and the select encoding.
// ----------------------------------------------------------------------------
module tb_mem_data_reg;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        RD;
    logic        SYL0N;
    logic        SYL1N;
    logic [27:0] SENSE;
    logic        TIME;
    logic        SYNC;
    logic        SER;
    logic        SERV;
    logic [13:0] MDR;
    logic        BUSY;
    logic        DONE;
    logic        RESTORE;
    logic [27:0] INH;
    logic        PERR;
    logic        SELERR;
    logic        OVR;

    int n_checks = 0;
    int n_fail   = 0;

    mem_data_reg dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .RD      (RD),
        .SYL0N   (SYL0N),
        .SYL1N   (SYL1N),
        .SENSE   (SENSE),
        .TIME    (TIME),
        .SYNC    (SYNC),
        .SER     (SER),
        .SERV    (SERV),
        .MDR     (MDR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESTORE (RESTORE),
        .INH     (INH),
        .PERR    (PERR),
        .SELERR  (SELERR),
        .OVR     (OVR)
    );

    always #5 CLK = ~CLK;

    // Phases of one read as seen by the model.
    localparam int PH_LOAD    = 1;
    localparam int PH_SHIFT   = 2;
    localparam int PH_RESTORE = 3;
    localparam int PH_DONE    = 4;

    // Runs one complete read from the strobe to the DONE cycle and checks
    // every cycle against the model. Returns at the falling edge of the DONE
    // cycle, so a following call issues its strobe inside that DONE cycle.
    //   tmode      0: TIME always 1, 1: TIME 1,0,1,... from the first shift
    //              cycle, 2: random TIME
    //   sync_after raise SYNC once this many bits have been delivered (-1: never)
    //   ovr_at     shift-cycle index at which a stray strobe is issued (-1: never)
    task automatic run_read(input logic [27:0] sense, input logic s0n, input logic s1n,
                            input int tmode, input int sync_after, input int ovr_at,
                            output logic [13:0] obs_ser);
        logic [13:0] exp_mdr;
        logic        exp_selerr;
        logic        exp_perr;
        logic        exp_ovr;
        logic        tim;
        logic        syn;
        logic [5:0]  exp_st;
        logic [5:0]  obs_st;
        logic [27:0] exp_inh;
        int          phase;
        int          sent;
        int          shift_cyc;
        int          shift_len;
        int          exp_done;
        bit          finished;

        case ({s0n, s1n})
            2'b01:   exp_mdr = sense[13:0];
            2'b10:   exp_mdr = sense[27:14];
            2'b00:   exp_mdr = sense[13:0];
            default: exp_mdr = sense[27:14];
        endcase
        exp_selerr = (s0n == s1n);
`ifdef MEM_PARITY_CHECK_EN
        exp_perr = (($countones(exp_mdr) % 2) == 0);
`else
        exp_perr = 1'b0;
`endif
        exp_ovr   = 1'b0;
        sent      = 0;
        shift_cyc = 0;
        finished  = 0;
        obs_ser   = '0;

        // Strobe cycle is index 0, LOAD is 1, shift cycles follow, then one
        // restore cycle, then the DONE cycle.
        if (tmode == 0)
            shift_len = (sync_after >= 0) ? sync_after + 1 : 14;
        else if (tmode == 1 && sync_after < 0)
            shift_len = 27;
        else
            shift_len = -1;
        exp_done = (shift_len < 0) ? -1 : shift_len + 3;

        RD = 1'b1; SENSE = sense; SYL0N = s0n; SYL1N = s1n; TIME = 1'b0; SYNC = 1'b0;
        @(posedge CLK); #1;
        phase = PH_LOAD;

        for (int k = 1; k < 300 && !finished; k++) begin
            // Outside the shift phase TIME, SYNC and SENSE are noise the
            // design must ignore.
            RD = 1'b0; SENSE = 28'($urandom); TIME = 1'($urandom); SYNC = 1'($urandom);
            tim = 1'b0;
            syn = 1'b0;
            if (phase == PH_SHIFT) begin
                if (tmode == 0)      tim = 1'b1;
                else if (tmode == 1) tim = ((shift_cyc % 2) == 0);
                else                 tim = 1'($urandom_range(0, 1));
                syn  = (sync_after >= 0 && sent == sync_after);
                TIME = tim;
                SYNC = syn;
                if (shift_cyc == ovr_at) begin
                    RD = 1'b1; SENSE = ~sense; SYL0N = ~s0n;
                end
            end
            @(negedge CLK);

            exp_st  = {phase != PH_DONE, phase == PH_SHIFT && tim && !syn,
                       phase == PH_RESTORE, phase == PH_DONE, exp_ovr, exp_selerr};
            obs_st  = {BUSY, SERV, RESTORE, DONE, OVR, SELERR};
            exp_inh = (phase == PH_RESTORE) ? sense : 28'd0;
            n_checks++;
            if (obs_st !== exp_st) begin
                n_fail++;
                $display("FAIL status phase=%0d cyc=%0d {BUSY,SERV,RESTORE,DONE,OVR,SELERR} got=%b exp=%b",
                         phase, k, obs_st, exp_st);
            end
            n_checks++;
            if (MDR !== exp_mdr) begin
                n_fail++;
                $display("FAIL mdr_hold cyc=%0d got=%h exp=%h", k, MDR, exp_mdr);
            end
            n_checks++;
            if (INH !== exp_inh) begin
                n_fail++;
                $display("FAIL inh phase=%0d cyc=%0d got=%h exp=%h", phase, k, INH, exp_inh);
            end

            if (phase == PH_SHIFT && tim && !syn) begin
                obs_ser[sent] = SER;
                n_checks++;
                if (SER !== exp_mdr[sent]) begin
                    n_fail++;
                    $display("FAIL ser_bit bit=%0d got=%b exp=%b", sent, SER, exp_mdr[sent]);
                end
            end else if (phase == PH_SHIFT && sent > 0) begin
                n_checks++;
                if (SER !== exp_mdr[sent - 1]) begin
                    n_fail++;
                    $display("FAIL ser_hold bit=%0d got=%b exp=%b", sent - 1, SER, exp_mdr[sent - 1]);
                end
            end

            if (phase == PH_DONE) begin
                n_checks++;
                if (PERR !== exp_perr) begin
                    n_fail++;
                    $display("FAIL perr got=%b exp=%b mdr=%h", PERR, exp_perr, exp_mdr);
                end
                if (exp_done >= 0) begin
                    n_checks++;
                    if (k != exp_done) begin
                        n_fail++;
                        $display("FAIL done_latency got=%0d exp=%0d", k, exp_done);
                    end
                end
                finished = 1;
            end

            case (phase)
                PH_LOAD:  phase = PH_SHIFT;
                PH_SHIFT: begin
                    if (RD) exp_ovr = 1'b1;
                    if (syn) begin
                        phase = PH_RESTORE;
                    end else if (tim) begin
                        sent++;
                        if (sent == 14) phase = PH_RESTORE;
                    end
                    shift_cyc++;
                end
                PH_RESTORE: phase = PH_DONE;
                default: ;
            endcase

            if (!finished) begin
                @(posedge CLK); #1;
            end
        end

        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_timeout phase=%0d sent=%0d", phase, sent);
        end
        RD = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; RD = 1'b0; SYL0N = 1'b1; SYL1N = 1'b1;
        SENSE = 28'd0; TIME = 1'b0; SYNC = 1'b0;
        repeat (2) @(posedge CLK);
        // A strobe held during reset must not start anything.
        #1 RD = 1'b1; SENSE = 28'hFFF_FFFF;
        @(negedge CLK);
        n_checks++;
        if ({SER, SERV, MDR, BUSY, DONE, RESTORE, INH, PERR, SELERR, OVR} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {SER, SERV, MDR, BUSY, DONE, RESTORE, INH, PERR, SELERR, OVR});
        end
        RD = 1'b0;
        RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_syl0_serial();
        logic [13:0] obs;
        logic [27:0] s;
        s = {14'($urandom), 14'h2AAB};
        run_read(s, 1'b0, 1'b1, 0, -1, -1, obs);
        // LSB-first stream 1,1,0,1,0,1,0,1,0,1,0,1,0,1 reassembles to 2AAB.
        n_checks++;
        if (obs !== 14'h2AAB) begin
            n_fail++;
            $display("FAIL syl0_serial_stream got=%h exp=2aab", obs);
        end
    endtask

    task automatic test_syl1_parity();
        logic [13:0] obs;
        logic        exp_perr;
`ifdef MEM_PARITY_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        run_read({14'h0003, 14'($urandom)}, 1'b1, 1'b0, 0, -1, -1, obs);
        // Flag must stay put through idle cycles after the read.
        repeat (3) @(negedge CLK);
        n_checks++;
        if (PERR !== exp_perr || MDR !== 14'h0003) begin
            n_fail++;
            $display("FAIL syl1_parity_sticky perr=%b exp=%b mdr=%h exp=0003", PERR, exp_perr, MDR);
        end
    endtask

    task automatic test_time_toggle();
        logic [13:0] obs;
        run_read(28'($urandom), 1'b0, 1'b1, 1, -1, -1, obs);
    endtask

    task automatic test_sync_abort();
        logic [13:0] obs;
        run_read(28'($urandom), 1'b1, 1'b0, 0, 5, -1, obs);
    endtask

    task automatic test_back_to_back();
        logic [13:0] obs;
        // Stray strobe mid-shift, then a new read issued in the DONE cycle.
        run_read(28'($urandom), 1'b0, 1'b1, 0, -1, 3, obs);
        run_read(28'($urandom), 1'b1, 1'b0, 0, -1, -1, obs);
    endtask

    task automatic test_reset_mid_shift();
        logic [13:0] obs;
        logic [27:0] s;
        s = 28'($urandom);
        RD = 1'b1; SENSE = 28'($urandom); SYL0N = 1'b0; SYL1N = 1'b1; TIME = 1'b1; SYNC = 1'b0;
        @(posedge CLK); #1;
        RD = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
        end
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_busy got=%b exp=1", BUSY);
        end
        #2 RSTN = 1'b0;
        #1;
        n_checks++;
        if ({SER, SERV, MDR, BUSY, DONE, RESTORE, INH, PERR, SELERR, OVR} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_mid_shift_outputs got=%h exp=0",
                     {SER, SERV, MDR, BUSY, DONE, RESTORE, INH, PERR, SELERR, OVR});
        end
        @(posedge CLK); #3;
        RSTN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({BUSY, SERV, RESTORE, DONE} !== 4'b0000) begin
                n_fail++;
                $display("FAIL post_reset_quiet cyc=%0d {BUSY,SERV,RESTORE,DONE} got=%b exp=0000",
                         i, {BUSY, SERV, RESTORE, DONE});
            end
        end
        run_read(s, 1'b0, 1'b0, 0, -1, -1, obs);
    endtask

    task automatic test_random();
        logic [13:0] obs;
        int          tmode;
        int          sync_after;
        int          ovr_at;
        for (int i = 0; i < 12; i++) begin
            tmode      = $urandom_range(0, 2);
            sync_after = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 13) : -1;
            ovr_at     = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : -1;
            run_read(28'($urandom), 1'($urandom), 1'($urandom), tmode, sync_after, ovr_at, obs);
            // Sometimes leave idle gaps between reads.
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_syl0_serial();
        test_syl1_parity();
        test_time_toggle();
        test_sync_abort();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
